// File: rtl/jelly_axi4_slave_ram.sv
`timescale 1ns/1ps
// AXI4 slave backed by a single-port RAM, one transaction at a time.
// Define JELLY_AXI4_SLAVE_RAM_BUSY_EN to throttle AW/AR/W ready with an LFSR.
module jelly_axi4_slave_ram #(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_SIZE  = 3,
  parameter int MEM_WIDTH      = 12,
  parameter int BUSY_RATE      = 0
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [AXI_ID_WIDTH-1:0]           s_axi4_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]         s_axi4_awaddr,
  input  logic [7:0]                        s_axi4_awlen,
  input  logic [2:0]                        s_axi4_awsize,
  input  logic [1:0]                        s_axi4_awburst,
  input  logic                              s_axi4_awvalid,
  output logic                              s_axi4_awready,
  input  logic [(8<<AXI_DATA_SIZE)-1:0]     s_axi4_wdata,
  input  logic [(1<<AXI_DATA_SIZE)-1:0]     s_axi4_wstrb,
  input  logic                              s_axi4_wlast,
  input  logic                              s_axi4_wvalid,
  output logic                              s_axi4_wready,
  output logic [AXI_ID_WIDTH-1:0]           s_axi4_bid,
  output logic [1:0]                        s_axi4_bresp,
  output logic                              s_axi4_bvalid,
  input  logic                              s_axi4_bready,
  input  logic [AXI_ID_WIDTH-1:0]           s_axi4_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]         s_axi4_araddr,
  input  logic [7:0]                        s_axi4_arlen,
  input  logic [2:0]                        s_axi4_arsize,
  input  logic [1:0]                        s_axi4_arburst,
  input  logic                              s_axi4_arvalid,
  output logic                              s_axi4_arready,
  output logic [AXI_ID_WIDTH-1:0]           s_axi4_rid,
  output logic [(8<<AXI_DATA_SIZE)-1:0]     s_axi4_rdata,
  output logic [1:0]                        s_axi4_rresp,
  output logic                              s_axi4_rlast,
  output logic                              s_axi4_rvalid,
  input  logic                              s_axi4_rready
);

  // state | meaning
  // IDLE  | arbitrate AW/AR
  // WRITE | accept W beats
  // WRESP | present B until bready
  // READ  | stream R beats from RAM
  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  localparam int DATA_W = 8 << AXI_DATA_SIZE;
  localparam int STRB_W = 1 << AXI_DATA_SIZE;

  state_t               state, state_next;
  logic [DATA_W-1:0]    mem [0:(1<<MEM_WIDTH)-1];
  logic                 prefer_write;
  logic [MEM_WIDTH-1:0] wr_addr, rd_addr;
  logic [7:0]           wr_len, wr_beat, rd_len, rd_beat;
  logic                 wr_fixed, rd_fixed, wr_err;
  logic                 busy, aw_sel, w_fire, w_final, w_last_bad;

`ifdef JELLY_AXI4_SLAVE_RAM_BUSY_EN
  logic [15:0] lfsr;
  always_ff @(posedge aclk) begin
    if (!aresetn) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
  assign busy = (lfsr[3:0] < 4'(BUSY_RATE));
`else
  logic unused_busy_rate;
  assign unused_busy_rate = ^4'(BUSY_RATE);
  assign busy = 1'b0;
`endif

  // Size and the address bits above the RAM window are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi4_awsize, s_axi4_arsize, s_axi4_awaddr, s_axi4_araddr};

  assign s_axi4_rresp = 2'b00;

  always_comb begin
    aw_sel         = s_axi4_awvalid && (!s_axi4_arvalid || prefer_write);
    s_axi4_awready = aresetn && (state == IDLE) && !busy && aw_sel;
    s_axi4_arready = aresetn && (state == IDLE) && !busy && s_axi4_arvalid && !aw_sel;
    s_axi4_wready  = aresetn && (state == WRITE) && !busy;
    s_axi4_bvalid  = aresetn && (state == WRESP);
    w_fire         = s_axi4_wvalid && s_axi4_wready;
    w_final        = (wr_beat == wr_len);
    w_last_bad     = (s_axi4_wlast != w_final);
    state_next     = state;
    case (state)
      IDLE: begin
        if (s_axi4_awready)      state_next = WRITE;
        else if (s_axi4_arready) state_next = READ;
      end
      WRITE:   if (w_fire && w_final) state_next = WRESP;
      WRESP:   if (s_axi4_bready) state_next = IDLE;
      READ:    if (s_axi4_rvalid && s_axi4_rready && s_axi4_rlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (w_fire) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s_axi4_wstrb[i]) mem[wr_addr][8*i +: 8] <= s_axi4_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      prefer_write  <= 1'b1;
      s_axi4_bid    <= '0;
      s_axi4_bresp  <= 2'b00;
      s_axi4_rid    <= '0;
      s_axi4_rdata  <= '0;
      s_axi4_rvalid <= 1'b0;
      s_axi4_rlast  <= 1'b0;
      wr_addr       <= '0;
      wr_len        <= '0;
      wr_beat       <= '0;
      wr_fixed      <= 1'b0;
      wr_err        <= 1'b0;
      rd_addr       <= '0;
      rd_len        <= '0;
      rd_beat       <= '0;
      rd_fixed      <= 1'b0;
    end else begin
      state <= state_next;
      if (s_axi4_awready) begin
        s_axi4_bid   <= s_axi4_awid;
        wr_addr      <= s_axi4_awaddr[MEM_WIDTH+AXI_DATA_SIZE-1:AXI_DATA_SIZE];
        wr_len       <= s_axi4_awlen;
        wr_beat      <= '0;
        wr_fixed     <= (s_axi4_awburst == 2'b00);
        wr_err       <= 1'b0;
        prefer_write <= 1'b0;
      end
      if (s_axi4_arready) begin
        s_axi4_rid   <= s_axi4_arid;
        rd_addr      <= s_axi4_araddr[MEM_WIDTH+AXI_DATA_SIZE-1:AXI_DATA_SIZE];
        rd_len       <= s_axi4_arlen;
        rd_fixed     <= (s_axi4_arburst == 2'b00);
        prefer_write <= 1'b1;
      end
      // The beat counter, not wlast, ends the burst; wlast only affects bresp.
      if (w_fire) begin
        wr_beat <= wr_beat + 8'd1;
        wr_err  <= wr_err | w_last_bad;
        if (!wr_fixed) wr_addr <= wr_addr + 1'b1;
        if (w_final) s_axi4_bresp <= (wr_err || w_last_bad) ? 2'b10 : 2'b00;
      end
      // rdata is the RAM output register: first fetch happens on entry, then one per R handshake.
      if (state == READ) begin
        if (!s_axi4_rvalid) begin
          s_axi4_rdata  <= mem[rd_addr];
          s_axi4_rvalid <= 1'b1;
          s_axi4_rlast  <= (rd_len == 8'd0);
          rd_beat       <= '0;
          if (!rd_fixed) rd_addr <= rd_addr + 1'b1;
        end else if (s_axi4_rready) begin
          if (s_axi4_rlast) begin
            s_axi4_rvalid <= 1'b0;
            s_axi4_rlast  <= 1'b0;
          end else begin
            s_axi4_rdata <= mem[rd_addr];
            s_axi4_rlast <= (rd_beat + 8'd1 == rd_len);
            rd_beat      <= rd_beat + 8'd1;
            if (!rd_fixed) rd_addr <= rd_addr + 1'b1;
          end
        end
      end
    end
  end

endmodule
